sv12_err_event_collector: RTL and testbench

Receiving end of the `always_comb` concurrent-check path. Each cycle it takes the per-cycle check result (a/e compare, qualified by `disable_error`), counts failures, captures the first failing tag and queues failing tags in a small FIFO. A testbench or CSR agent drains that FIFO through a valid/ready read port. It sits beside the checked logic in the same clock domain.

---
 rtl/sv12_err_event_collector.sv | 170 +++++++++++++++++
 tb/tb_sv12_err_event_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sv12_err_event_collector.sv
// Error event collector: counts check failures, latches the first
// failing tag and queues failing tags for a valid/ready reader.
module sv12_err_event_collector #(
    parameter int CNT_W = 8,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             clear,
    input  logic             chk_valid,
    input  logic             chk_a,
    input  logic             chk_e,
    input  logic [TAG_W-1:0] chk_tag,
    input  logic             disable_error,
    output logic [CNT_W-1:0] err_count,
    output logic [TAG_W-1:0] first_tag,
    output logic [1:0]       state,
    output logic             overflow,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_TRIP  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] first_q;
    logic             ovf_q;
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] head_d;
    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_nxt;
    logic [AW:0]      fill;
    logic             empty;
    logic             full;
    logic             fail;
    logic             pop;
    logic             push;
    logic             drop;
    logic             load_first;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill   = wr_ptr - rd_ptr;
    assign rd_nxt = rd_ptr + PONE;

    assign fail = chk_valid & (chk_a == chk_e) &
                  ~disable_error & (state_q != S_IDLE);
    assign pop  = ~empty & rd_ready;
    assign push = fail & (~full | pop);
    assign drop = fail & full & ~pop;

    assign load_first = fail & (state_q == S_ARMED);

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear overrides arm and fail
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (arm)  state_d = S_ARMED;
            S_ARMED: if (fail) state_d = S_TRIP;
            S_TRIP:  state_d = S_TRIP;
            default: state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    // saturating failure counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (fail && cnt_q != CMAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // first failing tag and sticky overflow flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            first_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (load_first) first_q <= chk_tag;
            if (drop)       ovf_q   <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= chk_tag;
        end
    end

    // FIFO pointers with wrap bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE;
            if (pop)  rd_ptr <= rd_nxt;
        end
    end

    // next registered head: bypass the incoming tag when the
    // queue is (or is about to become) empty
    always_comb begin
        head_d = head_q;
        if (empty) begin
            if (push) head_d = chk_tag;
        end else if (pop) begin
            if (fill == PONE) begin
                if (push) head_d = chk_tag;
            end else begin
                head_d = mem[rd_nxt[AW-1:0]];
            end
        end
    end

    // registered head entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
        end else if (clear) begin
            head_q <= '0;
        end else begin
            head_q <= head_d;
        end
    end

    assign err_count = cnt_q;
    assign first_tag = first_q;
    assign state     = state_q;
    assign overflow  = ovf_q;
    assign rd_valid  = ~empty;
    assign rd_tag    = head_q;

endmodule

// File: tb/tb_sv12_err_event_collector.sv
// Scoreboard bench for the error event collector: a behavioural
// queue model predicts every output and every popped tag.
module tb_sv12_err_event_collector;

    localparam int CNT_W = 3;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             arm = 1'b0;
    logic             clear = 1'b0;
    logic             chk_valid = 1'b0;
    logic             chk_a = 1'b0;
    logic             chk_e = 1'b0;
    logic [TAG_W-1:0] chk_tag = '0;
    logic             disable_error = 1'b0;
    logic             rd_ready = 1'b0;
    logic [CNT_W-1:0] err_count;
    logic [TAG_W-1:0] first_tag;
    logic [1:0]       state;
    logic             overflow;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;

    int n_chk = 0;
    int n_err = 0;

    int m_state;
    int m_cnt;
    int m_first;
    bit m_ovf;
    int exp_q[$];

    sv12_err_event_collector #(
        .CNT_W(CNT_W),
        .TAG_W(TAG_W),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .arm(arm),
        .clear(clear),
        .chk_valid(chk_valid),
        .chk_a(chk_a),
        .chk_e(chk_e),
        .chk_tag(chk_tag),
        .disable_error(disable_error),
        .err_count(err_count),
        .first_tag(first_tag),
        .state(state),
        .overflow(overflow),
        .rd_valid(rd_valid),
        .rd_tag(rd_tag),
        .rd_ready(rd_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_first = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_model();
        chk("state", 32'(state), m_state);
        chk("err_count", 32'(err_count), m_cnt);
        chk("first_tag", 32'(first_tag), m_first);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rd_valid", 32'(rd_valid), exp_q.size() != 0);
    endtask

    // one clock: drive, compare head before edge, update model, compare
    task automatic cyc(input bit a_arm, input bit a_clr,
                       input bit v, input bit a, input bit e,
                       input int tag, input bit dis, input bit rdy);
        bit f;
        bit pop;
        bit full;
        arm           = a_arm;
        clear         = a_clr;
        chk_valid     = v;
        chk_a         = a;
        chk_e         = e;
        chk_tag       = TAG_W'(tag);
        disable_error = dis;
        rd_ready      = rdy;
        #2;
        if (rdy && exp_q.size() != 0) begin
            chk("rd_tag", 32'(rd_tag), exp_q[0]);
        end
        @(posedge clock);
        if (a_clr) begin
            model_reset();
        end else begin
            f    = v && (a == e) && !dis && (m_state != 0);
            pop  = rdy && (exp_q.size() != 0);
            full = (exp_q.size() == DEPTH);
            if (pop) void'(exp_q.pop_front());
            if (f) begin
                if (m_cnt < CMAX) m_cnt++;
                if (m_state == 1) begin
                    m_state = 2;
                    m_first = tag;
                end
                if (!full || pop) exp_q.push_back(tag);
                else m_ovf = 1'b1;
            end
            if (a_arm && m_state == 0) m_state = 1;
        end
        #1;
        chk_model();
    endtask

    task automatic fail_t(input int tag, input bit rdy);
        cyc(0, 0, 1, 1, 1, tag, 0, rdy);
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_arm();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clear();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_cnt"}, 32'(err_count), 0);
        chk({tag, "_first"}, 32'(first_tag), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_rdv"}, 32'(rd_valid), 0);
        chk({tag, "_rdtag"}, 32'(rd_tag), 0);
    endtask

    initial begin
        model_reset();
        // reset held with a would-be failure on the inputs
        chk_valid = 1'b1;
        chk_a     = 1'b1;
        chk_e     = 1'b1;
        chk_tag   = 4'd3;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        // unarmed failures are ignored
        for (int i = 0; i < 3; i++) fail_t(i + 1, 0);
        chk("idle_cnt", 32'(err_count), 0);

        // arm, passes, then two failures
        do_arm();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 7, 0, 0);
        chk("armed_state", 32'(state), 1);
        fail_t(5, 0);
        fail_t(9, 0);
        chk("trip_state", 32'(state), 2);
        chk("trip_first", 32'(first_tag), 5);
        chk("trip_cnt", 32'(err_count), 2);
        for (int i = 0; i < 3; i++) idle(1);
        chk("drain_empty", 32'(rd_valid), 0);

        // masked failures
        do_clear();
        do_arm();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 8, 1, 0);
        chk("mask_cnt", 32'(err_count), 0);
        chk("mask_state", 32'(state), 1);
        chk("mask_rdv", 32'(rd_valid), 0);

        // full FIFO with no reader
        do_clear();
        do_arm();
        for (int i = 1; i <= 6; i++) fail_t(i, 0);
        chk("ovf_cnt", 32'(err_count), 6);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < 5; i++) idle(1);

        // full FIFO with a pop alongside the 5th push
        do_clear();
        do_arm();
        for (int i = 1; i <= 4; i++) fail_t(i, 0);
        fail_t(5, 1);
        chk("pp_ovf", 32'(overflow), 0);
        fail_t(6, 0);
        chk("pp_ovf6", 32'(overflow), 1);
        for (int i = 0; i < 5; i++) idle(1);

        // counter saturation
        do_clear();
        do_arm();
        for (int i = 0; i < 10; i++) fail_t(i, 1);
        chk("sat_cnt", 32'(err_count), CMAX);
        idle(1);
        chk("sat_hold", 32'(err_count), CMAX);

        // clear beats arm and a failure in the same cycle
        do_clear();
        do_arm();
        fail_t(3, 0);
        fail_t(7, 0);
        cyc(1, 1, 1, 1, 1, 4, 0, 0);
        chk("clr_state", 32'(state), 0);
        chk("clr_cnt", 32'(err_count), 0);
        chk("clr_rdv", 32'(rd_valid), 0);
        chk("clr_ovf", 32'(overflow), 0);

        // push into an empty FIFO while the reader is ready
        do_arm();
        fail_t(10, 1);
        chk("byp_rdv", 32'(rd_valid), 1);
        chk("byp_tag", 32'(rd_tag), 10);
        fail_t(11, 0);
        idle(1);

        // asynchronous reset mid-drain
        rd_ready = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
